// File: rtl/kernel_sysid_pkg.sv
// Shared constants and types for the system-ID register block.
// Address map, read-pipeline stage bundle and latency limits.
package kernel_sysid_pkg;

  localparam int unsigned ADDR_SYSID     = 0;
  localparam int unsigned ADDR_TIMESTAMP = 1;
  localparam int unsigned ADDR_VERSION   = 2;
  localparam int unsigned ADDR_CAPS      = 3;
  localparam int unsigned ADDR_UPTIME_LO = 4;
  localparam int unsigned ADDR_UPTIME_HI = 5;
  localparam int unsigned ADDR_SCRATCH   = 6;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rd_stage_t;

  // Extra delay stages after the first registered stage.
  // Out-of-range latencies are clamped into the legal range.
  function automatic int rd_pipe_depth(input int lat);
    int l;
    l = lat;
    if (l < RD_LAT_MIN) l = RD_LAT_MIN;
    if (l > RD_LAT_MAX) l = RD_LAT_MAX;
    return l - 1;
  endfunction

endpackage

// File: rtl/kernel_sysid_rdpipe.sv
// Valid+data delay line for the read return path.
// Depth 0 is a pass-through; reset flushes every stage.
module kernel_sysid_rdpipe
  import kernel_sysid_pkg::*;
#(
  parameter int DEPTH = 0
) (
  input  logic      clock,
  input  logic      reset_n,
  input  rd_stage_t in_i,
  output rd_stage_t out_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = clock ^ reset_n;
    assign out_o      = in_i;
  end else begin : g_pipe
    rd_stage_t pipe_q [DEPTH];

    // Shift stages toward the output; reset drops in-flight reads.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0] <= in_i;
        for (int i = 1; i < DEPTH; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign out_o = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/kernel_sysid_regfile.sv
// System-ID register block on an Avalon-MM slave port.
// Build constants, 64-bit uptime with hi-word snapshot, scratch.
module kernel_sysid_regfile
  import kernel_sysid_pkg::*;
#(
  parameter logic [31:0] SYSID_VALUE  = 32'h0000_CAFE,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter logic [31:0] VERSION      = 32'h0001_0000,
  parameter logic [31:0] CAPS         = 32'h0000_0000,
  parameter logic [31:0] SCRATCH_RST  = 32'h0000_0000,
  parameter int          ADDR_W       = 3,
  parameter int          READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam int DEPTH = rd_pipe_depth(READ_LATENCY);

  localparam logic [ADDR_W-1:0] A_ID  = ADDR_W'(ADDR_SYSID);
  localparam logic [ADDR_W-1:0] A_TS  = ADDR_W'(ADDR_TIMESTAMP);
  localparam logic [ADDR_W-1:0] A_VER = ADDR_W'(ADDR_VERSION);
  localparam logic [ADDR_W-1:0] A_CAP = ADDR_W'(ADDR_CAPS);
  localparam logic [ADDR_W-1:0] A_ULO = ADDR_W'(ADDR_UPTIME_LO);
  localparam logic [ADDR_W-1:0] A_UHI = ADDR_W'(ADDR_UPTIME_HI);
  localparam logic [ADDR_W-1:0] A_SCR = ADDR_W'(ADDR_SCRATCH);

  logic [63:0] uptime_q, uptime_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] rd_mux;
  rd_stage_t   st1_q, st1_d;
  rd_stage_t   pipe_out;

  logic hit_id, hit_ts, hit_ver, hit_cap;
  logic hit_ulo, hit_uhi, hit_scr;
  logic up_clr;

  assign hit_id  = (address == A_ID);
  assign hit_ts  = (address == A_TS);
  assign hit_ver = (address == A_VER);
  assign hit_cap = (address == A_CAP);
  assign hit_ulo = (address == A_ULO);
  assign hit_uhi = (address == A_UHI);
  assign hit_scr = (address == A_SCR);

  assign up_clr = write && hit_ulo && (byteenable != 4'b0000);

  // Read mux over current state (read-before-write).
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      hit_id:  rd_mux = SYSID_VALUE;
      hit_ts:  rd_mux = TIMESTAMP;
      hit_ver: rd_mux = VERSION;
      hit_cap: rd_mux = CAPS;
      hit_ulo: rd_mux = uptime_q[31:0];
      hit_uhi: rd_mux = snap_q;
      hit_scr: rd_mux = scratch_q;
      default: rd_mux = '0;
    endcase
  end

  // Next-state for uptime, snapshot, scratch and first read stage.
  always_comb begin
    uptime_d  = up_clr ? 64'd0 : uptime_q + 64'd1;
    snap_d    = snap_q;
    scratch_d = scratch_q;
    st1_d     = '0;
    if (read && hit_ulo) begin
      snap_d = uptime_q[63:32];
    end
    if (write && hit_scr) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          scratch_d[8*i +: 8] = writedata[8*i +: 8];
        end
      end
    end
    if (read) begin
      st1_d.valid = 1'b1;
      st1_d.data  = rd_mux;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      uptime_q  <= '0;
      snap_q    <= '0;
      scratch_q <= SCRATCH_RST;
      st1_q     <= '0;
    end else begin
      uptime_q  <= uptime_d;
      snap_q    <= snap_d;
      scratch_q <= scratch_d;
      st1_q     <= st1_d;
    end
  end

  kernel_sysid_rdpipe #(
    .DEPTH (DEPTH)
  ) u_rdpipe (
    .clock   (clock),
    .reset_n (reset_n),
    .in_i    (st1_q),
    .out_o   (pipe_out)
  );

  assign readdatavalid = pipe_out.valid;
  assign readdata      = pipe_out.valid ? pipe_out.data : 32'h0;

endmodule

// File: tb/tb_kernel_sysid_regfile.sv
// Bench for kernel_sysid_regfile at read latency 1 and 3.
// Reference model plus literal expectations on key reads.
module tb_kernel_sysid_regfile;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wd = '0;
  logic [3:0]  be = '0;

  logic [31:0] da, db;
  logic        va, vb;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  kernel_sysid_regfile #(.READ_LATENCY(1)) dut_a (
    .clock(clock), .reset_n(rst_n), .address(addr), .read(rd),
    .write(wr), .writedata(wd), .byteenable(be),
    .readdata(da), .readdatavalid(va)
  );

  kernel_sysid_regfile #(.READ_LATENCY(3)) dut_b (
    .clock(clock), .reset_n(rst_n), .address(addr), .read(rd),
    .write(wr), .writedata(wd), .byteenable(be),
    .readdata(db), .readdatavalid(vb)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];

  logic [63:0] m_up = '0;
  logic [31:0] m_snap = '0;
  logic [31:0] m_scr = '0;
  int          edge_n = 0;
  logic        eav = 1'b0, ebv = 1'b0;
  logic [31:0] ead = '0, ebd = '0;
  logic [63:0] force_val;

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'h0000_CAFE;
      3'd1: return 32'h0000_0000;
      3'd2: return 32'h0001_0000;
      3'd3: return 32'h0000_0000;
      3'd4: return m_up[31:0];
      3'd5: return m_snap;
      3'd6: return m_scr;
      default: return 32'h0;
    endcase
  endfunction

  // Model: a read accepted at edge n returns at edge n+L-1.
  always @(posedge clock) begin
    logic [31:0] v;
    logic [63:0] nup;
    edge_n = edge_n + 1;
    eav = 1'b0; ead = '0; ebv = 1'b0; ebd = '0;
    if (!rst_n) begin
      m_up = '0; m_snap = '0; m_scr = '0;
      qa.delete(); qb.delete();
    end else begin
      nup = m_up + 64'd1;
      if (rd) begin
        v = m_read(addr);
        qa.push_back('{due: edge_n, d: v});
        qb.push_back('{due: edge_n + 2, d: v});
        if (addr == 3'd4) m_snap = m_up[63:32];
      end
      if (wr && addr == 3'd6) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) m_scr[8*i +: 8] = wd[8*i +: 8];
      end
      if (wr && addr == 3'd4 && be != 4'b0) nup = '0;
      m_up = nup;
      if (qa.size() > 0 && qa[0].due == edge_n) begin
        eav = 1'b1; ead = qa[0].d; void'(qa.pop_front());
      end
      if (qb.size() > 0 && qb[0].due == edge_n) begin
        ebv = 1'b1; ebd = qb[0].d; void'(qb.pop_front());
      end
    end
    #1;
    checks++;
    if (va !== eav || da !== ead) begin
      failures++;
      $display("FAIL cyc%0d_lat1: got v=%b d=%h want v=%b d=%h",
               edge_n, va, da, eav, ead);
    end
    checks++;
    if (vb !== ebv || db !== ebd) begin
      failures++;
      $display("FAIL cyc%0d_lat3: got v=%b d=%h want v=%b d=%h",
               edge_n, vb, db, ebv, ebd);
    end
  end

  task automatic op(input logic r, input logic w, input logic [2:0] a,
                    input logic [31:0] d, input logic [3:0] b);
    rd = r; wr = w; addr = a; wd = d; be = b;
    @(negedge clock);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
  endtask

  task automatic set_up(input logic [63:0] v);
    force_val = v;
    force dut_a.uptime_q = force_val;
    force dut_b.uptime_q = force_val;
    m_up = v;
    #1;
    release dut_a.uptime_q;
    release dut_b.uptime_q;
  endtask

  task automatic lit(input string nm, input logic [31:0] exp, input bit on_b);
    logic        v, mv;
    logic [31:0] d, md;
    v  = on_b ? vb : va;
    d  = on_b ? db : da;
    mv = on_b ? ebv : eav;
    md = on_b ? ebd : ead;
    checks++;
    if (v !== 1'b1 || d !== exp) begin
      failures++;
      $display("FAIL %s: got v=%b d=%h want v=1 d=%h", nm, v, d, exp);
    end
    checks++;
    if (mv !== 1'b1 || md !== exp) begin
      failures++;
      $display("FAIL model_%s: got v=%b d=%h want v=1 d=%h", nm, mv, md, exp);
    end
  endtask

  task automatic lit_nv(input string nm, input bit on_b);
    logic v;
    v = on_b ? vb : va;
    checks++;
    if (v !== 1'b0) begin
      failures++;
      $display("FAIL %s: got v=%b want v=0", nm, v);
    end
  endtask

  initial begin
    @(negedge clock);
    rst_n = 1'b0;
    repeat (3) idle();
    lit_nv("reset_lat1", 1'b0);
    lit_nv("reset_lat3", 1'b1);
    rst_n = 1'b1;

    op(1, 0, 3'd0, 0, 0); lit("id", 32'h0000_CAFE, 0);
    op(1, 0, 3'd1, 0, 0); lit("ts", 32'h0, 0);
    op(1, 0, 3'd2, 0, 0); lit("ver", 32'h0001_0000, 0);
    op(1, 0, 3'd3, 0, 0); lit("caps", 32'h0, 0);
    idle(); idle();

    op(0, 1, 3'd6, 32'hAABB_CCDD, 4'b0101);
    op(1, 0, 3'd6, 0, 0); lit("scr_be5", 32'h00BB_00DD, 0);
    op(1, 0, 3'd7, 0, 0); lit("addr7", 32'h0, 0);
    op(0, 1, 3'd6, 32'h1234_5678, 4'b0000);
    op(0, 1, 3'd0, 32'h1234_5678, 4'b1111);
    op(0, 1, 3'd5, 32'h1234_5678, 4'b1111);
    op(1, 0, 3'd6, 0, 0); lit("scr_be0", 32'h00BB_00DD, 0);
    op(1, 1, 3'd6, 32'h1122_3344, 4'b1010);
    lit("scr_rbw", 32'h00BB_00DD, 0);
    op(1, 0, 3'd6, 0, 0); lit("scr_be_a", 32'h11BB_33DD, 0);
    op(1, 0, 3'd0, 0, 0); lit("id_ro", 32'h0000_CAFE, 0);

    set_up(64'h0000_0001_FFFF_FFFF);
    op(1, 0, 3'd4, 0, 0); lit("snap_lo", 32'hFFFF_FFFF, 0);
    idle(); idle();
    op(1, 0, 3'd5, 0, 0); lit("snap_hi", 32'h0000_0001, 0);

    set_up(64'd100);
    op(1, 1, 3'd4, 32'h0, 4'b0001); lit("clr_rbw", 32'd100, 0);
    idle();
    op(1, 0, 3'd4, 0, 0); lit("clr_after", 32'd1, 0);

    set_up(64'hFFFF_FFFF_FFFF_FFFF);
    op(1, 0, 3'd4, 0, 0); lit("wrap_pre", 32'hFFFF_FFFF, 0);
    op(1, 0, 3'd4, 0, 0); lit("wrap_lo", 32'h0, 0);
    op(1, 0, 3'd5, 0, 0); lit("wrap_hi", 32'h0, 0);
    idle(); idle(); idle();

    op(1, 0, 3'd0, 0, 0);
    op(1, 0, 3'd1, 0, 0);
    op(1, 0, 3'd2, 0, 0); lit("lat3_first", 32'h0000_CAFE, 1);
    rst_n = 1'b0;
    op(1, 0, 3'd3, 0, 0); lit_nv("lat3_flush0", 1'b1);
    idle(); lit_nv("lat3_flush1", 1'b1);
    rst_n = 1'b1;
    idle(); lit_nv("lat3_flush2", 1'b1);
    idle(); lit_nv("lat3_flush3", 1'b1);

    for (int i = 0; i < 16; i++) begin
      op(1'b1, i[0], 3'(i), 32'h1111_1111 * i, 4'(i));
    end
    repeat (5) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
